// File: rtl/mem_requester.sv
// CPU-side memory initiator: queues client cache-line requests in a small FIFO and
// issues them one at a time to memory, with completion timeout and ordered responses.
module mem_requester #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 512,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              buffer_addr_valid,
    input  logic              cl_req_valid,
    input  logic              cl_req_write,
    input  logic [ADDR_W-1:0] cl_req_addr,
    input  logic [DATA_W-1:0] cl_req_data,
    output logic              cl_req_ready,
    output logic              cl_rsp_valid,
    output logic              cl_rsp_write,
    output logic [DATA_W-1:0] cl_rsp_data,
    output logic              cl_rsp_error,
    input  logic              cl_rsp_ready,
    output logic              mem_req_valid,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    logic [ENT_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_req_ready;
    logic              w_push;
    logic              w_pop;
    logic [ENT_W-1:0]  w_head;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TMO_W-1:0]  r_tmo;
    logic [TMO_W-1:0]  w_tmo_nxt;
    logic              r_hold_write;
    logic [ADDR_W-1:0] r_hold_addr;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_mreq_valid;
    logic              w_mreq_valid_nxt;
    logic              r_rsp_valid;
    logic              w_rsp_valid_nxt;
    logic              r_rsp_write;
    logic              w_rsp_write_nxt;
    logic              r_rsp_error;
    logic              w_rsp_error_nxt;
    logic [DATA_W-1:0] r_rsp_data;
    logic [DATA_W-1:0] w_rsp_data_nxt;

    assign w_push = cl_req_valid && r_req_ready;
    assign w_pop  = (r_state == S_IDLE) && (r_count != CNT_W'(0)) && buffer_addr_valid;
    assign w_head = r_fifo[r_rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {cl_req_write, cl_req_addr, cl_req_data};
        end
    end

    // FIFO pointers, occupancy and registered ready; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= PTR_W'(0);
            r_rd_ptr    <= PTR_W'(0);
            r_count     <= CNT_W'(0);
            r_req_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count     <= w_count_nxt;
            r_req_ready <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    // Transaction FSM next-state and next values of the registered outputs.
    always_comb begin
        w_state_nxt      = r_state;
        w_tmo_nxt        = r_tmo;
        w_mreq_valid_nxt = r_mreq_valid;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_write_nxt  = r_rsp_write;
        w_rsp_error_nxt  = r_rsp_error;
        w_rsp_data_nxt   = r_rsp_data;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt      = S_ISSUE;
                    w_mreq_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    w_state_nxt      = S_WAIT;
                    w_mreq_valid_nxt = 1'b0;
                    w_tmo_nxt        = TMO_W'(0);
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_write_nxt = r_hold_write;
                    w_rsp_error_nxt = 1'b0;
                    w_rsp_data_nxt  = r_hold_write ? {DATA_W{1'b0}} : mem_rsp_data;
                end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_write_nxt = r_hold_write;
                    w_rsp_error_nxt = 1'b1;
                    w_rsp_data_nxt  = {DATA_W{1'b0}};
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            S_RESP: begin
                if (cl_rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_write_nxt = 1'b0;
                    w_rsp_error_nxt = 1'b0;
                    w_rsp_data_nxt  = {DATA_W{1'b0}};
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt      = S_IDLE;
                w_mreq_valid_nxt = 1'b0;
                w_rsp_valid_nxt  = 1'b0;
            end
        endcase
    end

    // FSM state, timeout counter, holding registers and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_tmo        <= TMO_W'(0);
            r_hold_write <= 1'b0;
            r_hold_addr  <= {ADDR_W{1'b0}};
            r_hold_data  <= {DATA_W{1'b0}};
            r_mreq_valid <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_write  <= 1'b0;
            r_rsp_error  <= 1'b0;
            r_rsp_data   <= {DATA_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_tmo        <= w_tmo_nxt;
            r_mreq_valid <= w_mreq_valid_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_write  <= w_rsp_write_nxt;
            r_rsp_error  <= w_rsp_error_nxt;
            r_rsp_data   <= w_rsp_data_nxt;
            if (w_pop) begin
                {r_hold_write, r_hold_addr, r_hold_data} <= w_head;
            end
        end
    end

    assign cl_req_ready  = r_req_ready;
    assign cl_rsp_valid  = r_rsp_valid;
    assign cl_rsp_write  = r_rsp_write;
    assign cl_rsp_error  = r_rsp_error;
    assign cl_rsp_data   = r_rsp_data;
    assign mem_req_valid = r_mreq_valid;
    assign mem_req_write = r_hold_write;
    assign mem_req_addr  = r_hold_addr;
    assign mem_req_data  = r_hold_data;
    assign busy          = (r_count != CNT_W'(0)) || (r_state != S_IDLE);

endmodule

// File: doc/mem_requester.md
Name: mem_requester

Overview:
- CPU-side initiator for the internal memory request/response interface.
- Buffers cache-line read/write requests from one CPU client in a small FIFO and issues them to the memory block one at a time.
- Waits for each completion, times out stalled transactions, and returns read data or write acknowledgements to the client.
- Sits between cpu subunits and memory; the cpu top packs its mem_* outputs into t_mem_tx and unpacks t_mem_rx into its mem_rsp_* inputs.

Parameters:
- ADDR_W, 32, cache-line address width (line offset into the host buffer).
- DATA_W, 512, cache-line data width.
- FIFO_DEPTH, 4, request FIFO entries; power of two, at least 2.
- TIMEOUT, 1024, cycles allowed in WAIT_RSP before error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous assert, active-low.
- buffer_addr_valid  in  1  host buffer address programmed; no issue while low.
- cl_req_valid  in  1  client request valid.
- cl_req_write  in  1  1=write, 0=read.
- cl_req_addr  in  ADDR_W  line address.
- cl_req_data  in  DATA_W  write data; ignored for reads.
- cl_req_ready  out  1  FIFO not full.
- cl_rsp_valid  out  1  response valid.
- cl_rsp_write  out  1  response is a write ack.
- cl_rsp_data  out  DATA_W  read data; 0 for write acks.
- cl_rsp_error  out  1  response is a timeout error.
- cl_rsp_ready  in  1  client accepts response.
- mem_req_valid  out  1  request to memory.
- mem_req_write  out  1  request type.
- mem_req_addr  out  ADDR_W  request address.
- mem_req_data  out  DATA_W  request write data.
- mem_req_ready  in  1  memory accepts request this cycle.
- mem_rsp_valid  in  1  single-cycle completion from memory.
- mem_rsp_data  in  DATA_W  read data with completion.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
Reset:
- All outputs 0, except cl_req_ready=1.
- FIFO empty, FSM in IDLE, timeout counter 0.
- Reset asserted mid-transaction discards the FIFO contents and the outstanding request; a late mem_rsp_valid after reset release is ignored in IDLE.

FIFO:
- Push when cl_req_valid && cl_req_ready.
- cl_req_ready = !full, registered.
- Pop on the cycle the FSM leaves IDLE.
- Simultaneous push and pop when full is not allowed, because ready is already low.
- Simultaneous push and pop otherwise keeps the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

FSM:
- IDLE: when FIFO non-empty and buffer_addr_valid=1, pop the head into holding registers and go to ISSUE. If buffer_addr_valid=0, stay in IDLE and keep the request queued.
- ISSUE: mem_req_* driven from the holding registers with mem_req_valid=1. Payload is held stable until mem_req_ready=1, then go to WAIT_RSP with the counter cleared.
- WAIT_RSP: on mem_rsp_valid, capture data (or 0 for a write) and go to RESP. Otherwise increment the counter; at TIMEOUT-1 go to RESP with error=1. mem_rsp_valid outside WAIT_RSP is dropped.
- RESP: cl_rsp_valid=1 with all cl_rsp_* fields stable until cl_rsp_ready=1, then go to IDLE.

Ordering and latency:
- At most one transaction outstanding; responses return in request order.
- Minimum latency, push to cl_rsp_valid: push at cycle 0, IDLE pop at cycle 1, ISSUE accepted at cycle 2, mem_rsp at cycle 3, cl_rsp_valid at cycle 4.
- busy is a combinational OR of FIFO non-empty and state != IDLE.

Test Plan:
- Read, ready memory: push read addr 0x10, mem_req_ready=1, mem_rsp_valid 1 cycle later with data 0xA5..A5 -> single mem_req read @0x10, then cl_rsp_valid with data 0xA5..A5, write=0, error=0; busy clears next cycle.
- Gating: buffer_addr_valid=0, push a write to 0x3 -> mem_req_valid stays 0 for 20 cycles. Raise buffer_addr_valid -> write issued, then cl_rsp write=1, data=0.
- FIFO full: hold buffer_addr_valid=0 and push 4 requests -> cl_req_ready=0 after the 4th push; a 5th push is not accepted. Release -> 4 responses in push order, addresses 0,1,2,3.
- Backpressure: mem_req_ready low for 5 cycles and cl_rsp_ready low for 3 cycles -> mem_req payload and cl_rsp payload remain stable throughout; exactly one request is issued.
- Timeout: TIMEOUT=16, request accepted but no mem_rsp_valid -> cl_rsp_error=1 exactly 16 cycles after acceptance. A mem_rsp_valid arriving afterwards produces no second response.
- Async reset mid-WAIT_RSP with 2 queued requests -> outputs return to reset values immediately with no clock edge; no responses after release; cl_req_ready=1.
